wishbone_arbiter: RTL and testbench

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arb_watchdog.sv | 38 +++
 rtl/wishbone_arbiter.sv | 140 ++++++++++++++
 tb/tb_wishbone_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
// The state encoding is also exported on the arbiter's state_o debug port.
package wb_arb_pkg;

    localparam int ADR_W = 16;
    localparam int DAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } wb_arb_state_e;

    function automatic logic [1:0] state_gnt(wb_arb_state_e s);
        case (s)
            ST_GNT0: return 2'b01;
            ST_GNT1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack-wait watchdog: counts unacknowledged strobe cycles of the granted master.
// expire_o is combinational on the strobe cycle that would bring the count to TIMEOUT_CYCLES.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // expire_o must not depend on clr_i: the arbiter derives clr_i from the grant it steers with expire_o.
    assign expire_o = inc_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master Wishbone arbiter with alternating priority on ties and no preemption.
// Define WB_ARB_TIMEOUT_EN to add the ack-wait watchdog, err termination and the ABORT state.
module wishbone_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       state_o
);

    // Handshake: a master owns a cycle while cyc is high; each stb beat completes in the cycle
    // the slave returns ack (or the watchdog returns err). The arbiter only steers, never buffers.

    wb_arb_state_e state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;   // 1: m1 was granted most recently
    logic          timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_inc;
    logic wd_clr;

    assign wd_inc = s_stb_o & ~s_ack_i;
    assign wd_clr = s_ack_i | (gnt_d != gnt_q);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (wd_inc),
        .clr_i   (wd_clr),
        .expire_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) state_d = ST_GNT0;
                else if (m1_cyc_i)                     state_d = ST_GNT1;
            end
            ST_GNT0: begin
                if (m0_cyc_i) begin
                    if (timeout) state_d = ST_ABORT;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (m1_cyc_i) begin
                    if (timeout) state_d = ST_ABORT;
                end else if (m0_cyc_i) begin
                    state_d = ST_GNT0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            // last_q still names the aborted master; wait for it to close its cycle.
            ST_ABORT: begin
                if (!(last_q ? m1_cyc_i : m0_cyc_i)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_GNT0) last_d = 1'b0;
        if (state_d == ST_GNT1) last_d = 1'b1;
        gnt_d = state_gnt(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        s_cyc_o = (m0_cyc_i & gnt_q[0]) | (m1_cyc_i & gnt_q[1]);
        s_stb_o = (m0_stb_i & gnt_q[0]) | (m1_stb_i & gnt_q[1]);
        s_we_o  = (m0_we_i  & gnt_q[0]) | (m1_we_i  & gnt_q[1]);
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt_q[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt_q[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = s_ack_i & gnt_q[0];
    assign m1_ack_o = s_ack_i & gnt_q[1];
    assign m0_err_o = timeout & gnt_q[0];
    assign m1_err_o = timeout & gnt_q[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: per-cycle vector table plus hand-written
// sequences for reset, alternation and (with WB_ARB_TIMEOUT_EN) the watchdog abort.
module tb_wishbone_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [15:0] m0_adr, m1_adr;
    logic [7:0]  m0_dat, m1_dat;
    logic [7:0]  m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [15:0] s_adr_o;
    logic [7:0]  s_dat_o;
    logic [7:0]  s_dat;
    logic        s_ack, s_ack_drv, ack_auto;
    logic [1:0]  gnt_o, state_o;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    assign s_ack = ack_auto ? s_stb_o : s_ack_drv;

    wishbone_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(gnt_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [1:0]  cyc, stb, we;
        logic [15:0] a0, a1;
        logic [7:0]  d0, d1, sd;
        logic        ack;
        logic [1:0]  e_gnt;
        logic [2:0]  e_csw;
        logic [15:0] e_adr;
        logic [7:0]  e_dat;
        logic [1:0]  e_ack;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl[NV];

    function automatic vec_t v(string n, logic [1:0] cyc, logic [1:0] stb, logic [1:0] we,
                               logic [15:0] a0, logic [7:0] d0, logic [15:0] a1, logic [7:0] d1,
                               logic [7:0] sd, logic ack, logic [1:0] eg, logic [2:0] ecsw,
                               logic [15:0] ea, logic [7:0] ed, logic [1:0] eack);
        vec_t r;
        r.name = n; r.cyc = cyc; r.stb = stb; r.we = we;
        r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.sd = sd; r.ack = ack;
        r.e_gnt = eg; r.e_csw = ecsw; r.e_adr = ea; r.e_dat = ed; r.e_ack = eack;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
        s_dat = '0; s_ack_drv = 0;
    endtask

    task automatic apply(input vec_t t);
        m0_cyc = t.cyc[0]; m0_stb = t.stb[0]; m0_we = t.we[0]; m0_adr = t.a0; m0_dat = t.d0;
        m1_cyc = t.cyc[1]; m1_stb = t.stb[1]; m1_we = t.we[1]; m1_adr = t.a1; m1_dat = t.d1;
        s_dat = t.sd; s_ack_drv = t.ack;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int m0_rem, m1_rem, idle_gaps, n;
        logic m0_pause, m1_pause, started;
        logic [1:0] prev;

        // both tie after reset (m0 first, then m1 with no idle gap)
        tbl[0]  = v("b_idle",     2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[1]  = v("b_both_req", 2'b11, 2'b11, 2'b01, 16'h1111, 8'h11, 16'h2222, 8'h22, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[2]  = v("b_m0_gnt",   2'b11, 2'b11, 2'b01, 16'h1111, 8'h11, 16'h2222, 8'h22, 8'h00, 0, 2'b01, 3'b111, 16'h1111, 8'h11, 2'b00);
        tbl[3]  = v("b_m0_ack",   2'b11, 2'b11, 2'b01, 16'h1111, 8'h11, 16'h2222, 8'h22, 8'hC3, 1, 2'b01, 3'b111, 16'h1111, 8'h11, 2'b01);
        tbl[4]  = v("b_m0_drop",  2'b10, 2'b10, 2'b00, 16'h0000, 8'h00, 16'h2222, 8'h22, 8'h00, 0, 2'b01, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[5]  = v("b_m1_gnt",   2'b10, 2'b10, 2'b00, 16'h0000, 8'h00, 16'h2222, 8'h22, 8'h00, 0, 2'b10, 3'b110, 16'h2222, 8'h22, 2'b00);
        tbl[6]  = v("b_m1_ack",   2'b10, 2'b10, 2'b00, 16'h0000, 8'h00, 16'h2222, 8'h22, 8'h3C, 1, 2'b10, 3'b110, 16'h2222, 8'h22, 2'b10);
        tbl[7]  = v("b_m1_drop",  2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b10, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[8]  = v("b_idle2",    2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        // m0 read of 0x1234, slave returns 0xA5
        tbl[9]  = v("a_req",      2'b01, 2'b01, 2'b00, 16'h1234, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[10] = v("a_gnt",      2'b01, 2'b01, 2'b00, 16'h1234, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b01, 3'b110, 16'h1234, 8'h00, 2'b00);
        tbl[11] = v("a_wait",     2'b01, 2'b01, 2'b00, 16'h1234, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b01, 3'b110, 16'h1234, 8'h00, 2'b00);
        tbl[12] = v("a_ack",      2'b01, 2'b01, 2'b00, 16'h1234, 8'h00, 16'h0000, 8'h00, 8'hA5, 1, 2'b01, 3'b110, 16'h1234, 8'h00, 2'b01);
        tbl[13] = v("a_drop",     2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b01, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[14] = v("a_idle",     2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        // m1 write 0x5A to 0x00FF, m0 requests mid-transfer and must wait
        tbl[15] = v("c_req",      2'b10, 2'b10, 2'b10, 16'h0000, 8'h00, 16'h00FF, 8'h5A, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[16] = v("c_gnt",      2'b10, 2'b10, 2'b10, 16'h0000, 8'h00, 16'h00FF, 8'h5A, 8'h00, 0, 2'b10, 3'b111, 16'h00FF, 8'h5A, 2'b00);
        tbl[17] = v("c_m0_req",   2'b11, 2'b11, 2'b10, 16'h1234, 8'h77, 16'h00FF, 8'h5A, 8'h00, 0, 2'b10, 3'b111, 16'h00FF, 8'h5A, 2'b00);
        tbl[18] = v("c_hold",     2'b11, 2'b11, 2'b10, 16'h1234, 8'h77, 16'h00FF, 8'h5A, 8'h00, 0, 2'b10, 3'b111, 16'h00FF, 8'h5A, 2'b00);
        tbl[19] = v("c_m1_ack",   2'b11, 2'b11, 2'b10, 16'h1234, 8'h77, 16'h00FF, 8'h5A, 8'h42, 1, 2'b10, 3'b111, 16'h00FF, 8'h5A, 2'b10);
        tbl[20] = v("c_m1_drop",  2'b01, 2'b01, 2'b00, 16'h1234, 8'h77, 16'h0000, 8'h00, 8'h00, 0, 2'b10, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[21] = v("c_m0_gnt",   2'b01, 2'b01, 2'b00, 16'h1234, 8'h77, 16'h0000, 8'h00, 8'h00, 0, 2'b01, 3'b110, 16'h1234, 8'h77, 2'b00);
        tbl[22] = v("c_m0_ack",   2'b01, 2'b01, 2'b00, 16'h1234, 8'h77, 16'h0000, 8'h00, 8'h99, 1, 2'b01, 3'b110, 16'h1234, 8'h77, 2'b01);
        tbl[23] = v("c_drop",     2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b01, 3'b000, 16'h0000, 8'h00, 2'b00);
        tbl[24] = v("c_idle",     2'b00, 2'b00, 2'b00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 0, 2'b00, 3'b000, 16'h0000, 8'h00, 2'b00);

        // reset state
        ack_auto = 0;
        drive_idle();
        s_dat = 8'h5C;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_gnt", {30'd0, gnt_o}, 32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_bus", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
        check("rst_m0_dat", {24'd0, m0_dat_o}, 32'h5C);
        check("rst_term", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
        s_dat = 8'h00;
        rst_n = 1;

        // table-driven cycles
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(tbl[i]);
            @(negedge clk);
            check({tbl[i].name, "_gnt"}, {30'd0, gnt_o}, {30'd0, tbl[i].e_gnt});
            check({tbl[i].name, "_csw"}, {29'd0, s_cyc_o, s_stb_o, s_we_o}, {29'd0, tbl[i].e_csw});
            check({tbl[i].name, "_adr"}, {16'd0, s_adr_o}, {16'd0, tbl[i].e_adr});
            check({tbl[i].name, "_sdat"}, {24'd0, s_dat_o}, {24'd0, tbl[i].e_dat});
            check({tbl[i].name, "_ack"}, {30'd0, m1_ack_o, m0_ack_o}, {30'd0, tbl[i].e_ack});
            check({tbl[i].name, "_m0dat"}, {24'd0, m0_dat_o}, {24'd0, tbl[i].sd});
            check({tbl[i].name, "_m1dat"}, {24'd0, m1_dat_o}, {24'd0, tbl[i].sd});
            check({tbl[i].name, "_err"}, {30'd0, m1_err_o, m0_err_o}, 32'd0);
        end

        // asynchronous reset mid-transfer, then m0 wins the tie
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'hABCD; m1_cyc = 1; m1_stb = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_o != 2'b10 && gnt_o != 2'b01 && n < 8);
        // last grant before this was m0, so m1 takes the tie here
        check("r_pre_gnt", {30'd0, gnt_o}, 32'd2);
        @(posedge clk); #1;
        s_ack_drv = 1; s_dat = 8'h6E;
        #1 rst_n = 0;
        #1;
        check("r_async_gnt", {30'd0, gnt_o}, 32'd0);
        check("r_async_bus", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        check("r_async_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        check("r_async_dat", {24'd0, m1_dat_o}, 32'h6E);
        s_ack_drv = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("r_release_gnt", {30'd0, gnt_o}, 32'd1);
        drive_idle();
        repeat (3) @(negedge clk);

        // continuous requests from both: grants must alternate without idle cycles
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        ack_auto = 1;
        m0_rem = 3; m1_rem = 3; m0_pause = 0; m1_pause = 0;
        idle_gaps = 0; started = 0; prev = 2'b00; n = 0;
        while ((m0_rem > 0 || m1_rem > 0) && n < 80) begin
            @(posedge clk); #1;
            m0_cyc = (m0_rem > 0) && !m0_pause; m0_stb = m0_cyc;
            m1_cyc = (m1_rem > 0) && !m1_pause; m1_stb = m1_cyc;
            m0_pause = 0; m1_pause = 0;
            @(negedge clk);
            n++;
            if (gnt_o != prev && gnt_o != 2'b00) begin
                if (exp_q.size() > 0) begin
                    check("d_grant", {30'd0, gnt_o}, {30'd0, exp_q.pop_front()});
                end else begin
                    checks++; errors++;
                    $display("FAIL d_extra_grant: got %0h expected none", gnt_o);
                end
            end
            if (started && gnt_o == 2'b00) idle_gaps++;
            if (gnt_o != 2'b00) started = 1;
            prev = gnt_o;
            if (m0_ack_o) begin m0_rem--; m0_pause = 1; end
            if (m1_ack_o) begin m1_rem--; m1_pause = 1; end
        end
        check("d_done", {31'd0, (m0_rem == 0 && m1_rem == 0)}, 32'd1);
        check("d_left", exp_q.size(), 32'd0);
        check("d_idle_gaps", idle_gaps, 32'd0);
        ack_auto = 0;
        drive_idle();
        repeat (3) @(negedge clk);

`ifdef WB_ARB_TIMEOUT_EN
        // slave never acks: err on the 4th strobe cycle, then bus held idle until m0 drops cyc
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0BAD;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_o != 2'b01 && n < 8);
        check("t_gnt", {30'd0, gnt_o}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t_err_cycle%0d", k), {31'd0, m0_err_o}, {31'd0, (k == 4)});
            check($sformatf("t_stb_cycle%0d", k), {31'd0, s_stb_o}, 32'd1);
            if (k < 4) @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t_abort_state", {30'd0, state_o}, 32'd3);
            check("t_abort_bus", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
            check("t_abort_err", {31'd0, m0_err_o}, 32'd0);
        end
        @(posedge clk); #1;
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        @(negedge clk);
        check("t_back_idle", {30'd0, state_o}, 32'd0);
        drive_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
